// File: rtl/xf100_dram_arb.sv
// Two-port arbiter in front of the single-ported data RAM: fixed core priority,
// a starvation counter that forces an ext grant, and a 1-cycle registered response.
module xf100_dram_arb #(
    parameter int AW       = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          core_req_valid,
    output logic          core_req_ready,
    input  logic          core_req_wen,
    input  logic [3:0]    core_req_mask,
    input  logic [AW-1:0] core_req_addr,
    input  logic [31:0]   core_req_wdat,
    output logic          core_rsp_valid,
    output logic [31:0]   core_rsp_rdat,

    input  logic          ext_req_valid,
    output logic          ext_req_ready,
    input  logic          ext_req_wen,
    input  logic [3:0]    ext_req_mask,
    input  logic [AW-1:0] ext_req_addr,
    input  logic [31:0]   ext_req_wdat,
    output logic          ext_rsp_valid,
    output logic [31:0]   ext_rsp_rdat,

    output logic          ram_cs,
    output logic          ram_wen,
    output logic [3:0]    ram_mask,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_wdat,
    input  logic [31:0]   ram_rdat,

    output logic [3:0]    wait_cnt_o
);

    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    logic       force_ext;
    logic       grant_ext;
    logic       grant_core;

    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       rsp_core_q, rsp_core_d;
    logic       rsp_ext_q,  rsp_ext_d;
    logic       rsp_rd_q,   rsp_rd_d;

    // Valid/ready: a request is accepted in the cycle its ready is high; the
    // requester holds it stable until then. Responses have no ready and are
    // never stalled. Grants are masked while rst is high.
    always_comb begin
        force_ext  = ext_req_valid & (wait_cnt_q == WAIT_MAX);
        grant_ext  = ~rst & ext_req_valid & (~core_req_valid | force_ext);
        grant_core = ~rst & core_req_valid & ~grant_ext;
    end

    always_comb begin
        ram_cs   = grant_core | grant_ext;
        ram_wen  = 1'b0;
        ram_mask = '0;
        ram_addr = '0;
        ram_wdat = '0;
        if (grant_core) begin
            ram_wen  = core_req_wen;
            ram_mask = core_req_mask;
            ram_addr = core_req_addr;
            ram_wdat = core_req_wdat;
        end else if (grant_ext) begin
            ram_wen  = ext_req_wen;
            ram_mask = ext_req_mask;
            ram_addr = ext_req_addr;
            ram_wdat = ext_req_wdat;
        end
    end

    // Counts consecutive ext losses; any other outcome restarts the count.
    always_comb begin
        wait_cnt_d = '0;
        if (ext_req_valid & grant_core) begin
            wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? WAIT_MAX : wait_cnt_q + 4'd1;
        end
        rsp_core_d = grant_core;
        rsp_ext_d  = grant_ext;
        rsp_rd_d   = (grant_core & ~core_req_wen) | (grant_ext & ~ext_req_wen);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= '0;
            rsp_core_q <= 1'b0;
            rsp_ext_q  <= 1'b0;
            rsp_rd_q   <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            rsp_core_q <= rsp_core_d;
            rsp_ext_q  <= rsp_ext_d;
            rsp_rd_q   <= rsp_rd_d;
        end
    end

    assign core_req_ready = grant_core;
    assign ext_req_ready  = grant_ext;
    assign core_rsp_valid = rsp_core_q;
    assign ext_rsp_valid  = rsp_ext_q;
    assign core_rsp_rdat  = (rsp_core_q & rsp_rd_q) ? ram_rdat : 32'h0;
    assign ext_rsp_rdat   = (rsp_ext_q & rsp_rd_q) ? ram_rdat : 32'h0;
    assign wait_cnt_o     = wait_cnt_q;

endmodule

// File: tb/tb_xf100_dram_arb.sv
// Directed bench for xf100_dram_arb with a behavioural RAM, a reference memory
// and per-port expected-response queues.
module tb_xf100_dram_arb;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          core_req_valid = 1'b0, core_req_wen = 1'b0;
    logic [3:0]    core_req_mask = '0;
    logic [AW-1:0] core_req_addr = '0;
    logic [31:0]   core_req_wdat = '0;
    logic          ext_req_valid = 1'b0, ext_req_wen = 1'b0;
    logic [3:0]    ext_req_mask = '0;
    logic [AW-1:0] ext_req_addr = '0;
    logic [31:0]   ext_req_wdat = '0;
    logic          core_req_ready, ext_req_ready;
    logic          core_rsp_valid, ext_rsp_valid;
    logic [31:0]   core_rsp_rdat, ext_rsp_rdat;
    logic          ram_cs, ram_wen;
    logic [3:0]    ram_mask;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdat;
    logic [31:0]   ram_rdat = '0;
    logic [3:0]    wait_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_core_q[$];
    logic [31:0] exp_ext_q[$];
    logic        core_due = 1'b0;
    logic        ext_due  = 1'b0;
    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];

    xf100_dram_arb #(.AW(AW), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
        .core_req_wen(core_req_wen), .core_req_mask(core_req_mask),
        .core_req_addr(core_req_addr), .core_req_wdat(core_req_wdat),
        .core_rsp_valid(core_rsp_valid), .core_rsp_rdat(core_rsp_rdat),
        .ext_req_valid(ext_req_valid), .ext_req_ready(ext_req_ready),
        .ext_req_wen(ext_req_wen), .ext_req_mask(ext_req_mask),
        .ext_req_addr(ext_req_addr), .ext_req_wdat(ext_req_wdat),
        .ext_rsp_valid(ext_rsp_valid), .ext_rsp_rdat(ext_rsp_rdat),
        .ram_cs(ram_cs), .ram_wen(ram_wen), .ram_mask(ram_mask),
        .ram_addr(ram_addr), .ram_wdat(ram_wdat), .ram_rdat(ram_rdat),
        .wait_cnt_o(wait_cnt_o)
    );

    // ---- clock / RAM model ----
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_wen) begin
                for (int b = 0; b < 4; b++)
                    if (ram_mask[b]) mem[ram_addr[7:0]][8*b +: 8] <= ram_wdat[8*b +: 8];
            end else begin
                ram_rdat <= mem[ram_addr[7:0]];
            end
        end
    end

    // ---- checking ----
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---- driver tasks ----
    task automatic set_core(input logic v, input logic w, input logic [3:0] m,
                            input logic [AW-1:0] a, input logic [31:0] d);
        core_req_valid = v; core_req_wen = w; core_req_mask = m;
        core_req_addr = a; core_req_wdat = d;
    endtask

    task automatic set_ext(input logic v, input logic w, input logic [3:0] m,
                           input logic [AW-1:0] a, input logic [31:0] d);
        ext_req_valid = v; ext_req_wen = w; ext_req_mask = m;
        ext_req_addr = a; ext_req_wdat = d;
    endtask

    // One cycle: check grant/RAM/counter now, responses owed from last cycle,
    // then record what this cycle's expected grant owes next cycle.
    task automatic tick(input logic gc, input logic ge, input logic [3:0] wc);
        logic [31:0] e;
        logic [AW-1:0] a;
        logic w;
        logic [3:0] m;
        logic [31:0] d;
        @(negedge clk);
        chk("core_rsp_valid", 32'(core_rsp_valid), 32'(core_due));
        e = (core_due && exp_core_q.size() > 0) ? exp_core_q.pop_front() : 32'h0;
        chk("core_rsp_rdat", core_rsp_rdat, e);
        chk("ext_rsp_valid", 32'(ext_rsp_valid), 32'(ext_due));
        e = (ext_due && exp_ext_q.size() > 0) ? exp_ext_q.pop_front() : 32'h0;
        chk("ext_rsp_rdat", ext_rsp_rdat, e);
        chk("core_req_ready", 32'(core_req_ready), 32'(gc));
        chk("ext_req_ready", 32'(ext_req_ready), 32'(ge));
        chk("wait_cnt_o", 32'(wait_cnt_o), 32'(wc));
        chk("ram_cs", 32'(ram_cs), 32'(gc | ge));
        w = 1'b0; m = '0; a = '0; d = '0;
        if (gc) begin w = core_req_wen; m = core_req_mask; a = core_req_addr; d = core_req_wdat; end
        else if (ge) begin w = ext_req_wen; m = ext_req_mask; a = ext_req_addr; d = ext_req_wdat; end
        chk("ram_addr", 32'(ram_addr), 32'(a));
        chk("ram_ctl", {27'h0, ram_wen, ram_mask}, {27'h0, w, m});
        chk("ram_wdat", ram_wdat, d);
        if (gc | ge) begin
            if (w) begin
                for (int b = 0; b < 4; b++)
                    if (m[b]) ref_mem[a[7:0]][8*b +: 8] = d[8*b +: 8];
                e = 32'h0;
            end else begin
                e = ref_mem[a[7:0]];
            end
            if (gc) exp_core_q.push_back(e);
            else    exp_ext_q.push_back(e);
        end
        core_due = gc;
        ext_due  = ge;
        @(posedge clk);
        #1;
    endtask

    task automatic flush_pending();
        core_due = 1'b0;
        ext_due  = 1'b0;
        exp_core_q.delete();
        exp_ext_q.delete();
    endtask

    // ---- directed sequence ----
    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end

        // reset state, with requests present
        tick(1'b0, 1'b0, 4'd0);
        set_core(1'b1, 1'b0, 4'hF, 16'h0005, 32'h0);
        set_ext(1'b1, 1'b0, 4'hF, 16'h0006, 32'h0);
        tick(1'b0, 1'b0, 4'd0);
        set_core(1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
        set_ext(1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
        rst = 1'b0;
        tick(1'b0, 1'b0, 4'd0);

        // core only: write then read back
        set_core(1'b1, 1'b1, 4'hF, 16'h0010, 32'hA5A5_1234);
        tick(1'b1, 1'b0, 4'd0);
        set_core(1'b1, 1'b0, 4'hF, 16'h0010, 32'h0);
        tick(1'b1, 1'b0, 4'd0);
        set_core(1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
        tick(1'b0, 1'b0, 4'd0);

        // simultaneous single requests
        set_core(1'b1, 1'b0, 4'hF, 16'h0001, 32'h0);
        set_ext(1'b1, 1'b0, 4'hF, 16'h0002, 32'h0);
        tick(1'b1, 1'b0, 4'd0);
        set_core(1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
        tick(1'b0, 1'b1, 4'd1);
        set_ext(1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
        tick(1'b0, 1'b0, 4'd0);

        // starvation: core continuous, ext held
        set_ext(1'b1, 1'b0, 4'hF, 16'h0040, 32'h0);
        for (int i = 0; i < 4; i++) begin
            set_core(1'b1, 1'b0, 4'hF, 16'(16'h0030 + i), 32'h0);
            tick(1'b1, 1'b0, 4'(i));
        end
        set_core(1'b1, 1'b0, 4'hF, 16'h0034, 32'h0);
        tick(1'b0, 1'b1, 4'd4);
        set_ext(1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
        tick(1'b1, 1'b0, 4'd0);
        set_core(1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
        tick(1'b0, 1'b0, 4'd0);

        // byte write, zero-mask write, read-after-write across ports
        set_core(1'b1, 1'b1, 4'hF, 16'h0020, 32'hFFFF_FFFF);
        tick(1'b1, 1'b0, 4'd0);
        set_core(1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
        set_ext(1'b1, 1'b1, 4'b0001, 16'h0020, 32'h0000_00AB);
        tick(1'b0, 1'b1, 4'd0);
        set_ext(1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
        set_core(1'b1, 1'b0, 4'hF, 16'h0020, 32'h0);
        tick(1'b1, 1'b0, 4'd0);
        set_core(1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
        set_ext(1'b1, 1'b1, 4'b0000, 16'h0020, 32'h1234_5678);
        tick(1'b0, 1'b1, 4'd0);
        set_ext(1'b1, 1'b0, 4'hF, 16'h0020, 32'h0);
        tick(1'b0, 1'b1, 4'd0);
        set_ext(1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
        set_core(1'b1, 1'b1, 4'hF, 16'h0050, 32'h0BAD_F00D);
        tick(1'b1, 1'b0, 4'd0);
        set_core(1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
        set_ext(1'b1, 1'b0, 4'hF, 16'h0050, 32'h0);
        tick(1'b0, 1'b1, 4'd0);
        set_ext(1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
        tick(1'b0, 1'b0, 4'd0);

        // reset mid-operation: pending core read response is lost
        set_core(1'b1, 1'b0, 4'hF, 16'h0010, 32'h0);
        tick(1'b1, 1'b0, 4'd0);
        set_ext(1'b1, 1'b0, 4'hF, 16'h0002, 32'h0);
        rst = 1'b1;
        flush_pending();
        tick(1'b0, 1'b0, 4'd0);
        tick(1'b0, 1'b0, 4'd0);
        rst = 1'b0;
        tick(1'b1, 1'b0, 4'd0);
        set_core(1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
        tick(1'b0, 1'b1, 4'd1);
        set_ext(1'b0, 1'b0, 4'h0, 16'h0, 32'h0);

        // idle with random-looking but unused request fields
        for (int i = 0; i < 10; i++) begin
            set_core(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                     16'($urandom_range(0, 255)), $urandom);
            tick(1'b0, 1'b0, 4'd0);
        end

        chk("core_q_empty", 32'(exp_core_q.size()), 32'd0);
        chk("ext_q_empty", 32'(exp_ext_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/xf100_dram_arb.md
Name: xf100_dram_arb

Overview:
- Two-requester arbiter in front of the single-ported synchronous data RAM.
- Port 0 ("core") is driven by the EXU load/store path. Port 1 ("ext") is driven by the debug/DMA master.
- Fixed core priority, with a starvation counter that forces an ext grant after MAX_WAIT lost cycles.
- Each port gets a registered response one cycle after its request is granted.

Parameters:
- AW, 16: RAM word address width; equals XF100_DATA_RAM_AW.
- MAX_WAIT, 4: consecutive ext losses before ext is forced to win. Legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- core_req_valid  in  1  core request present
- core_req_ready  out  1  core request granted this cycle
- core_req_wen  in  1  1=write, 0=read
- core_req_mask  in  4  byte enables, bit i = byte i
- core_req_addr  in  AW  word address
- core_req_wdat  in  32  write data
- core_rsp_valid  out  1  core response pulse
- core_rsp_rdat  out  32  read data; 0 for writes
- ext_req_valid, ext_req_ready, ext_req_wen, ext_req_mask, ext_req_addr, ext_req_wdat: same as the core_ signals, for port 1
- ext_rsp_valid, ext_rsp_rdat: same as the core_ signals, for port 1
- ram_cs  out  1  RAM select
- ram_wen  out  1  RAM write enable
- ram_mask  out  4  RAM byte enables
- ram_addr  out  AW  RAM address
- ram_wdat  out  32  RAM write data
- ram_rdat  in  32  RAM read data, valid the cycle after ram_cs with ram_wen=0
- wait_cnt_o  out  4  current starvation count (debug visibility)

Behaviour:
- Grant (combinational, same cycle):
  - force_ext = ext_req_valid & (wait_cnt == MAX_WAIT).
  - grant_ext = ext_req_valid & (~core_req_valid | force_ext).
  - grant_core = core_req_valid & ~grant_ext.
  - core_req_ready = grant_core; ext_req_ready = grant_ext. At most one is 1.
  - ready never depends on rsp state: the RAM accepts a new access every cycle.
- RAM drive:
  - ram_cs = grant_core | grant_ext.
  - ram_wen, ram_mask, ram_addr, ram_wdat are muxed from the winning port.
  - With no grant, all RAM outputs are 0.
- Starvation counter wait_cnt (4 bits):
  - Increments when ext_req_valid & grant_core.
  - Clears to 0 on grant_ext or when ext_req_valid=0.
  - Saturates at MAX_WAIT and never exceeds it.
- Response pipeline (1-cycle latency):
  - Registers rsp_core, rsp_ext and rsp_rd load each cycle from grant_core, grant_ext and the winner's ~wen.
  - core_rsp_valid = rsp_core; ext_rsp_valid = rsp_ext.
  - X_rsp_rdat = (rsp_X & rsp_rd) ? ram_rdat : 0.
  - Writes complete in the RAM in the grant cycle. Their rsp pulse is only an acknowledge, with rdat=0.
  - Back-to-back grants yield back-to-back responses. Responses are never dropped and never backpressured.
- Read-after-write: an ext read of an address the core wrote in the previous cycle returns the new data. No forwarding logic is required, because the RAM is written at the edge that ends the grant cycle.
- Mask: passed through unmodified. A mask of 4'b0000 is legal; it is still granted and acknowledged.
- Reset:
  - Asynchronous assertion clears wait_cnt, rsp_core, rsp_ext and rsp_rd.
  - Therefore core_rsp_valid=0, ext_rsp_valid=0, both rsp_rdat=0 and wait_cnt_o=0 during reset.
  - While rst=1, both ready outputs and ram_cs are forced to 0 regardless of req_valid.
  - A response pending when rst asserts is lost. Requesters must discard outstanding transactions on reset.
- Requesters must hold a request stable until ready. The arbiter keeps no request storage.

Test Plan:
- Core only. Write addr 0x0010, wdat 0xA5A5_1234, mask 4'hF; next cycle read 0x0010 → core_rsp_valid pulses after each grant; second response has rdat 0xA5A51234, first has rdat 0. ext_rsp_valid stays 0 throughout.
- Simultaneous single requests. Core reads 0x0001, ext reads 0x0002 in the same cycle → core granted in cycle 0, ext in cycle 1. wait_cnt goes 1 then 0. core_rsp_valid in cycle 1, ext_rsp_valid in cycle 2.
- Starvation. core_req_valid held 1 continuously, ext_req_valid held 1, MAX_WAIT=4 → core wins cycles 0-3 and ext wins cycle 4 (wait_cnt_o = 0,1,2,3,4,0). Core wins again from cycle 5.
- Byte write. Pre-fill 0xFFFF_FFFF at 0x0020; ext writes wdat 0x0000_00AB with mask 4'b0001; core reads 0x0020 → rdat 0xFFFF_FFAB.
- Reset mid-operation. Assert rst on the cycle after a core read grant → core_rsp_valid never pulses for it. During reset ram_cs=0 with both req_valid=1. After release, the first grant goes to core and wait_cnt_o starts at 0.
- Idle. No req_valid for 10 cycles → ram_cs=0, ram_addr=0, both rsp_valid=0, wait_cnt_o=0.
